// File: rtl/lampfpu_log_arb_if.sv
// Requester and datapath bundle for the shared bf16 log unit arbiter.
// slave: arbiter side; master: requesters plus log datapath side.
interface lampfpu_log_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*16-1:0] op_i;
    logic [NUM_REQ-1:0]    gnt_o;

    logic                  doLog_o;
    logic                  s_op_o;
    logic [7:0]            e_op_o;
    logic [6:0]            f_op_o;
    logic                  isZ_op_o;
    logic                  isInf_op_o;
    logic                  isSNAN_op_o;
    logic                  isQNAN_op_o;

    logic                  s_res_i;
    logic [7:0]            e_res_i;
    logic [6:0]            f_res_i;
    logic                  valid_i;
    logic                  isOverflow_i;
    logic                  isUnderflow_i;
    logic                  isToRound_i;

    logic                  rsp_valid_o;
    logic [ID_W-1:0]       rsp_id_o;
    logic [15:0]           rsp_data_o;
    logic [3:0]            rsp_flags_o;

    modport slave (
        input  req_i, op_i,
        input  s_res_i, e_res_i, f_res_i,
        input  valid_i, isOverflow_i, isUnderflow_i, isToRound_i,
        output gnt_o, doLog_o, s_op_o, e_op_o, f_op_o,
        output isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o,
        output rsp_valid_o, rsp_id_o, rsp_data_o, rsp_flags_o
    );

    modport master (
        output req_i, op_i,
        output s_res_i, e_res_i, f_res_i,
        output valid_i, isOverflow_i, isUnderflow_i, isToRound_i,
        input  gnt_o, doLog_o, s_op_o, e_op_o, f_op_o,
        input  isZ_op_o, isInf_op_o, isSNAN_op_o, isQNAN_op_o,
        input  rsp_valid_o, rsp_id_o, rsp_data_o, rsp_flags_o
    );
endinterface

// File: rtl/lampfpu_log_arb.sv
// Round-robin arbiter/sequencer sharing one bf16 log datapath.
// Ports: clk, rst (async, active-high), bus (slave modport).
module lampfpu_log_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 8
) (
    input logic             clk,
    input logic             rst,
    lampfpu_log_arb_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SETUP, FIRE, WAIT} state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] rr, pick, id_q;
    logic            found;
    logic [ID_W:0]   idx;
    logic [15:0]     op_q, op_sel;
    logic [CW-1:0]   cnt;
    logic            busy, timed_out;
    logic [7:0]      e_q;
    logic [6:0]      f_q;
    logic            e_max, f_nz;

    // First pending requester at or after rr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, rr} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!found && bus.req_i[idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        op_sel = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (pick == ID_W'(k))
                op_sel = bus.op_i[k*16 +: 16];
    end

    assign timed_out = (cnt == CW'(TIMEOUT));

    always_comb begin
        state_n     = state;
        bus.doLog_o = 1'b0;
        bus.gnt_o   = '0;
        unique case (state)
            IDLE: begin
                if (found && !rst) begin
                    bus.gnt_o = NUM_REQ'(1) << pick;
                    state_n   = SETUP;
                end
            end
            SETUP: state_n = FIRE;
            FIRE: begin
                bus.doLog_o = 1'b1;
                state_n     = WAIT;
            end
            WAIT: begin
                if (bus.valid_i || timed_out)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand and flags stay stable from SETUP through WAIT because the
    // datapath samples the flags a cycle before the fields.
    assign busy  = (state != IDLE);
    assign e_q   = op_q[14:7];
    assign f_q   = op_q[6:0];
    assign e_max = &e_q;
    assign f_nz  = |f_q;

    assign bus.s_op_o      = busy & op_q[15];
    assign bus.e_op_o      = busy ? e_q : '0;
    assign bus.f_op_o      = busy ? f_q : '0;
    assign bus.isZ_op_o    = busy & ~|e_q;
    assign bus.isInf_op_o  = busy & e_max & ~f_nz;
    assign bus.isSNAN_op_o = busy & e_max & f_nz & ~f_q[6];
    assign bus.isQNAN_op_o = busy & e_max & f_nz & f_q[6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            rr              <= '0;
            op_q            <= '0;
            id_q            <= '0;
            cnt             <= '0;
            bus.rsp_valid_o <= 1'b0;
            bus.rsp_id_o    <= '0;
            bus.rsp_data_o  <= '0;
            bus.rsp_flags_o <= '0;
        end else begin
            state           <= state_n;
            bus.rsp_valid_o <= 1'b0;
            if (state == IDLE && found) begin
                op_q <= op_sel;
                id_q <= pick;
                rr   <= (pick == ID_W'(NUM_REQ-1)) ? '0 : pick + 1'b1;
            end
            if (state == FIRE)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (state == WAIT) begin
                if (bus.valid_i) begin
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_id_o    <= id_q;
                    bus.rsp_data_o  <= {bus.s_res_i, bus.e_res_i, bus.f_res_i};
                    bus.rsp_flags_o <= {1'b0, bus.isOverflow_i,
                                        bus.isUnderflow_i, bus.isToRound_i};
                end else if (timed_out) begin
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_id_o    <= id_q;
                    bus.rsp_data_o  <= 16'h7FC0;
                    bus.rsp_flags_o <= 4'b1000;
                end
            end
        end
    end
endmodule

// File: tb/tb_lampfpu_log_arb.sv
// Scoreboard bench for lampfpu_log_arb with a behavioural log datapath.
// Ports: none; drives the arbiter through its interface.
module tb_lampfpu_log_arb;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 8;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [15:0]     data;
        logic [3:0]      flags;
        int              lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lampfpu_log_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

    lampfpu_log_arb #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t        sbq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          gnt_cyc = 0;
    int          n_gnt   = 0;
    int          n_rsp   = 0;
    int          m_rr    = 0;
    int          last_id = 0;
    bit          pend    = 1'b0;
    bit          hang    = 1'b0;
    bit          fire_seen = 1'b0;
    logic [15:0] cur_op  = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    // log(1.0) = 0; any other operand gets a recognisable mangling.
    function automatic logic [15:0] dp(input logic [15:0] op);
        return (op == 16'h3F80) ? 16'h0000 : (op ^ 16'h5A5A);
    endfunction

    // {zero, inf, snan, qnan}
    function automatic logic [3:0] cls(input logic [15:0] op);
        logic [7:0] e;
        logic [6:0] f;
        e = op[14:7];
        f = op[6:0];
        if (e == 8'hFF && f != 0) return f[6] ? 4'b0001 : 4'b0010;
        if (e == 8'hFF) return 4'b0100;
        if (e == 8'h00) return 4'b1000;
        return 4'b0000;
    endfunction

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int p);
        for (int i = 0; i < NUM_REQ; i++)
            if (r[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath model: valid one cycle after doLog, result from operand pins.
    always @(negedge clk) fire_seen <= bus.doLog_o && !hang;

    always @(posedge clk) begin : dpm
        logic [15:0] op, r;
        #1;
        op = {bus.s_op_o, bus.e_op_o, bus.f_op_o};
        r  = dp(op);
        bus.valid_i       = fire_seen;
        bus.s_res_i       = r[15];
        bus.e_res_i       = r[14:7];
        bus.f_res_i       = r[6:0];
        bus.isOverflow_i  = fire_seen & op[0];
        bus.isUnderflow_i = fire_seen & op[1];
        bus.isToRound_i   = fire_seen & op[2];
    end

    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        logic [NUM_REQ-1:0] eg;
        logic exp_dl;
        if (!rst) begin
            if (bus.rsp_valid_o) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("rsp_id", 32'(bus.rsp_id_o), 32'(e.id));
                    check("rsp_data", 32'(bus.rsp_data_o), 32'(e.data));
                    check("rsp_flags", 32'(bus.rsp_flags_o), 32'(e.flags));
                    check("rsp_lat", 32'(cyc - gnt_cyc), 32'(e.lat));
                end
                pend = 1'b0;
                n_rsp++;
                check("ops_idle", {bus.s_op_o, bus.e_op_o, bus.f_op_o,
                      bus.isZ_op_o, bus.isInf_op_o, bus.isSNAN_op_o,
                      bus.isQNAN_op_o}, 32'd0);
            end
            if (pend && cyc > gnt_cyc) begin
                check("op_hold", {bus.s_op_o, bus.e_op_o, bus.f_op_o},
                      32'(cur_op));
                check("cls_hold", {bus.isZ_op_o, bus.isInf_op_o,
                      bus.isSNAN_op_o, bus.isQNAN_op_o}, 32'(cls(cur_op)));
            end
            exp_dl = pend && (cyc - gnt_cyc == 2);
            if (exp_dl || bus.doLog_o)
                check("doLog", 32'(bus.doLog_o), 32'(exp_dl));
            k  = pend ? -1 : rr_pick(bus.req_i, m_rr);
            eg = (k < 0) ? '0 : NUM_REQ'(1) << k;
            if (|eg || |bus.gnt_o)
                check("gnt", 32'(bus.gnt_o), 32'(eg));
            if (k >= 0) begin
                pend    = 1'b1;
                gnt_cyc = cyc;
                cur_op  = bus.op_i[k*16 +: 16];
                e.id    = ID_W'(k);
                e.data  = hang ? 16'h7FC0 : dp(cur_op);
                e.flags = hang ? 4'b1000
                               : {1'b0, cur_op[0], cur_op[1], cur_op[2]};
                e.lat   = hang ? TIMEOUT + 4 : 4;
                sbq.push_back(e);
                m_rr    = (k + 1) % NUM_REQ;
                last_id = k;
                n_gnt++;
            end
        end
    end

    task automatic run(input logic [NUM_REQ-1:0] mask, input int nops,
                       input bit drop);
        int g0, r0, bud;
        g0 = n_gnt;
        r0 = n_rsp;
        bus.req_i = mask;
        for (int i = 0; i < nops; i++) begin
            bud = 0;
            while (n_gnt < g0 + i + 1 && bud < 200) begin
                @(posedge clk);
                bud++;
            end
            if (bud >= 200) begin
                check("gnt_wait", 32'd0, 32'd1);
                break;
            end
            #1;
            if (drop) bus.req_i[last_id] = 1'b0;
        end
        bus.req_i = '0;
        bud = 0;
        while (n_rsp < r0 + nops && bud < 200) begin
            @(posedge clk);
            bud++;
        end
        #1;
        check("rsp_count", 32'(n_rsp - r0), 32'(nops));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int r0, bud;
        bus.req_i = '0;
        bus.op_i  = '0;
        bus.valid_i = 1'b0;
        bus.s_res_i = 1'b0;
        bus.e_res_i = '0;
        bus.f_res_i = '0;
        bus.isOverflow_i  = 1'b0;
        bus.isUnderflow_i = 1'b0;
        bus.isToRound_i   = 1'b0;
        #2;
        check("rst_ctl", {bus.gnt_o, bus.doLog_o, bus.rsp_valid_o,
              bus.rsp_id_o, bus.rsp_flags_o}, 32'd0);
        check("rst_data", {bus.rsp_data_o, bus.s_op_o, bus.e_op_o,
              bus.f_op_o}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        bus.op_i = {16'h4127, 16'h3F04, 16'h4042, 16'h3F80};
        run(4'b0001, 1, 1'b1);

        bus.op_i = {16'h7F81, 16'h7FC1, 16'h7F80, 16'h0000};
        run(4'b1111, 4, 1'b1);

        bus.op_i = {16'h4127, 16'h3F04, 16'h4042, 16'h4001};
        run(4'b1111, 5, 1'b0);

        run(4'b0100, 1, 1'b1);
        run(4'b1001, 2, 1'b1);
        run(4'b0001, 1, 1'b1);

        hang = 1'b1;
        run(4'b0001, 1, 1'b1);

        // Abandon an operation in WAIT with an async reset.
        bus.req_i = 4'b0100;
        r0  = n_gnt;
        bud = 0;
        while (n_gnt == r0 && bud < 50) begin
            @(posedge clk);
            bud++;
        end
        check("rst_gnt_seen", 32'(n_gnt - r0), 32'd1);
        #1 bus.req_i = '0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_ctl", {bus.gnt_o, bus.doLog_o, bus.rsp_valid_o,
              bus.rsp_id_o, bus.rsp_flags_o, bus.isZ_op_o, bus.isInf_op_o,
              bus.isSNAN_op_o, bus.isQNAN_op_o}, 32'd0);
        check("arst_data", {bus.rsp_data_o, bus.s_op_o, bus.e_op_o,
              bus.f_op_o}, 32'd0);
        sbq.delete();
        pend = 1'b0;
        m_rr = 0;
        hang = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        r0 = n_rsp;
        repeat (20) @(posedge clk);
        #1;
        check("no_rsp_after_rst", 32'(n_rsp - r0), 32'd0);

        run(4'b1010, 1, 1'b1);
        check("last_id_after_rst", 32'(last_id), 32'd1);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
